// File: rtl/sprite_mover_compositor.sv
`default_nettype none
// ============================================================================
// Module      : sprite_mover_compositor
// Description : Moves a 16x16 2-bit-indexed sprite once per frame, bouncing
//               between parameterised bounds. Compares every scan position
//               against the sprite window and returns the palette colour one
//               cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
//
// SPRITE_DATA packing: cell (row, col) is at bits [2*(row*16+col) +: 2],
// so row 0 / column 0 sits in the least significant bits.
// PALETTE packing: entry n is at bits [24*n +: 24], stored as {R,G,B}.
// Entry 0 is the transparent index.
module sprite_mover_compositor #(
    parameter int           SCALE_SHIFT = 3,
    parameter int           START_X     = 500,
    parameter int           START_Y     = 150,
    parameter int           MIN_X       = 300,
    parameter int           MAX_X       = 1000,
    parameter int           MIN_Y       = 0,
    parameter int           MAX_Y       = 600,
    parameter int           STEP_X      = 5,
    parameter int           STEP_Y      = 0,
    parameter logic [511:0] SPRITE_DATA = '0,
    parameter logic [95:0]  PALETTE     = 96'hFFFFFF_8ED8ED_05C5FF_000000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic        i_v_sync,
    input  logic        i_enable,
    output logic [7:0]  o_red,
    output logic [7:0]  o_green,
    output logic [7:0]  o_blue,
    output logic        o_sprite_hit,
    output logic [15:0] o_pos_x,
    output logic [15:0] o_pos_y
);

    // Bounds and steps widened to 17 bits so the forward sum and the
    // left-bound test can never wrap.
    localparam logic [16:0] c_MIN_X   = 17'(MIN_X);
    localparam logic [16:0] c_MAX_X   = 17'(MAX_X);
    localparam logic [16:0] c_STEP_X  = 17'(STEP_X);
    localparam logic [16:0] c_MIN_Y   = 17'(MIN_Y);
    localparam logic [16:0] c_MAX_Y   = 17'(MAX_Y);
    localparam logic [16:0] c_STEP_Y  = 17'(STEP_Y);
    localparam logic [15:0] c_START_X = 16'(START_X);
    localparam logic [15:0] c_START_Y = 16'(START_Y);

    // Direction encoding: 0 = towards larger coordinates (right / down).
    localparam logic c_DIR_FWD  = 1'b0;
    localparam logic c_DIR_BACK = 1'b1;

    // ------------------------------------------------------------------
    // Frame tick
    // ------------------------------------------------------------------
    logic r_vsync_d;
    logic w_tick;

    assign w_tick = i_v_sync & ~r_vsync_d;

    // Remember the previous vsync level; resets high so a held-high vsync does not tick on release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vsync_d <= 1'b1;
        end else begin
            r_vsync_d <= i_v_sync;
        end
    end

    // ------------------------------------------------------------------
    // Motion state
    // ------------------------------------------------------------------
    logic [15:0] r_pos_x;
    logic [15:0] r_pos_y;
    logic        r_dir_x;
    logic        r_dir_y;
    logic        r_flip_x;
    logic        r_flip_y;

    logic [16:0] w_fwd_x;
    logic [15:0] w_next_x;
    logic        w_next_dir_x;
    logic        w_next_flip_x;

    logic [16:0] w_fwd_y;
    logic [15:0] w_next_y;
    logic        w_next_dir_y;
    logic        w_next_flip_y;

    // Candidate X update: step, clamping and bouncing at either bound.
    always_comb begin
        w_fwd_x       = {1'b0, r_pos_x} + c_STEP_X;
        w_next_x      = r_pos_x;
        w_next_dir_x  = r_dir_x;
        w_next_flip_x = r_flip_x;
        if (r_dir_x == c_DIR_FWD) begin
            if (w_fwd_x >= c_MAX_X) begin
                w_next_x      = c_MAX_X[15:0];
                w_next_dir_x  = c_DIR_BACK;
                w_next_flip_x = 1'b1;
            end else begin
                w_next_x = w_fwd_x[15:0];
            end
        end else begin
            // Test before subtracting so the position never underflows.
            if ({1'b0, r_pos_x} < (c_MIN_X + c_STEP_X)) begin
                w_next_x      = c_MIN_X[15:0];
                w_next_dir_x  = c_DIR_FWD;
                w_next_flip_x = 1'b0;
            end else begin
                w_next_x = r_pos_x - c_STEP_X[15:0];
            end
        end
    end

    // Candidate Y update, same bounce rule as X with down as the forward direction.
    always_comb begin
        w_fwd_y       = {1'b0, r_pos_y} + c_STEP_Y;
        w_next_y      = r_pos_y;
        w_next_dir_y  = r_dir_y;
        w_next_flip_y = r_flip_y;
        if (r_dir_y == c_DIR_FWD) begin
            if (w_fwd_y >= c_MAX_Y) begin
                w_next_y      = c_MAX_Y[15:0];
                w_next_dir_y  = c_DIR_BACK;
                w_next_flip_y = 1'b1;
            end else begin
                w_next_y = w_fwd_y[15:0];
            end
        end else begin
            if ({1'b0, r_pos_y} < (c_MIN_Y + c_STEP_Y)) begin
                w_next_y      = c_MIN_Y[15:0];
                w_next_dir_y  = c_DIR_FWD;
                w_next_flip_y = 1'b0;
            end else begin
                w_next_y = r_pos_y - c_STEP_Y[15:0];
            end
        end
    end

    // Commit one motion step per enabled frame tick; otherwise hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pos_x  <= c_START_X;
            r_pos_y  <= c_START_Y;
            r_dir_x  <= c_DIR_FWD;
            r_dir_y  <= c_DIR_FWD;
            r_flip_x <= 1'b0;
            r_flip_y <= 1'b0;
        end else if (w_tick && i_enable) begin
            r_pos_x  <= w_next_x;
            r_pos_y  <= w_next_y;
            r_dir_x  <= w_next_dir_x;
            r_dir_y  <= w_next_dir_y;
            r_flip_x <= w_next_flip_x;
            r_flip_y <= w_next_flip_y;
        end
    end

    assign o_pos_x = r_pos_x;
    assign o_pos_y = r_pos_y;

    // ------------------------------------------------------------------
    // Pixel lookup
    // ------------------------------------------------------------------
    logic [16:0] w_dx;
    logic [16:0] w_dy;
    logic [16:0] w_cell_x;
    logic [16:0] w_cell_y;
    logic        w_in_win;
    logic [3:0]  w_col;
    logic [3:0]  w_row;
    logic [1:0]  w_idx;
    logic [23:0] w_rgb;

    // 17-bit offsets: bit 16 set means the scan point lies before the sprite.
    assign w_dx     = {1'b0, i_x} - {1'b0, r_pos_x};
    assign w_dy     = {1'b0, i_y} - {1'b0, r_pos_y};
    assign w_cell_x = w_dx >> SCALE_SHIFT;
    assign w_cell_y = w_dy >> SCALE_SHIFT;

    // Window test, mirrored grid address and palette fetch for the current scan point.
    always_comb begin
        // Inside exactly when the cell offset is 0..15 with no borrow.
        w_in_win = (w_cell_x[16:4] == 13'd0) && (w_cell_y[16:4] == 13'd0);
        // 15 - n on four bits is the bitwise complement.
        w_col    = r_flip_x ? ~w_cell_x[3:0] : w_cell_x[3:0];
        w_row    = r_flip_y ? ~w_cell_y[3:0] : w_cell_y[3:0];
        w_idx    = SPRITE_DATA[{w_row, w_col, 1'b0} +: 2];
        case (w_idx)
            2'd0:    w_rgb = PALETTE[23:0];
            2'd1:    w_rgb = PALETTE[47:24];
            2'd2:    w_rgb = PALETTE[71:48];
            default: w_rgb = PALETTE[95:72];
        endcase
    end

    logic [23:0] r_rgb;
    logic        r_hit;

    // Register the pixel result; it sees pre-update position/flips on a tick edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rgb <= 24'h000000;
            r_hit <= 1'b0;
        end else begin
            r_rgb <= w_in_win ? w_rgb : 24'h000000;
            r_hit <= w_in_win && (w_idx != 2'd0);
        end
    end

    assign o_red        = r_rgb[23:16];
    assign o_green      = r_rgb[15:8];
    assign o_blue       = r_rgb[7:0];
    assign o_sprite_hit = r_hit;

endmodule

`default_nettype wire

// File: tb/tb_sprite_mover_compositor.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_mover_compositor
// Description : Directed self-checking bench for sprite_mover_compositor.
//               Instance A uses default motion parameters; instance B uses a
//               narrow X range and a large Y step to exercise both bounces.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_mover_compositor;

    // Single opaque cell at row 2, column 6 (cell index 38 -> bits 77:76).
    localparam logic [511:0] c_SPRITE = 512'd1 << 76;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        v_sync = 1'b1;
    logic        en_a = 1'b0;
    logic        en_b = 1'b0;
    logic [15:0] px = 16'd0;
    logic [15:0] py = 16'd0;

    logic [7:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;
    logic        hit_a, hit_b;
    logic [15:0] pos_x_a, pos_y_a, pos_x_b, pos_y_b;

    int n_checks = 0;
    int n_fails  = 0;

    int exp_xb [7] = '{312, 307, 302, 300, 305, 310, 312};
    int exp_yb [7] = '{250, 350, 450, 550, 600, 500, 400};

    always #5 clk = ~clk;

    sprite_mover_compositor #(
        .SPRITE_DATA (c_SPRITE)
    ) dut_a (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_x          (px),
        .i_y          (py),
        .i_v_sync     (v_sync),
        .i_enable     (en_a),
        .o_red        (red_a),
        .o_green      (green_a),
        .o_blue       (blue_a),
        .o_sprite_hit (hit_a),
        .o_pos_x      (pos_x_a),
        .o_pos_y      (pos_y_a)
    );

    sprite_mover_compositor #(
        .START_X     (307),
        .MIN_X       (300),
        .MAX_X       (312),
        .STEP_Y      (100),
        .SPRITE_DATA (c_SPRITE)
    ) dut_b (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_x          (px),
        .i_y          (py),
        .i_v_sync     (v_sync),
        .i_enable     (en_b),
        .o_red        (red_b),
        .o_green      (green_b),
        .o_blue       (blue_b),
        .o_sprite_hit (hit_b),
        .o_pos_x      (pos_x_b),
        .o_pos_y      (pos_y_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame tick: vsync high for one cycle then low again.
    task automatic tick();
        v_sync = 1'b1;
        @(negedge clk);
        v_sync = 1'b0;
        @(negedge clk);
    endtask

    // Present a scan point and check instance A's registered result one cycle later.
    task automatic pix_a(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic [23:0] rgb, input logic hit);
        px = x;
        py = y;
        @(negedge clk);
        chk({tag, "_rgb"}, {red_a, green_a, blue_a}, rgb);
        chk({tag, "_hit"}, hit_a, hit);
    endtask

    task automatic pix_b(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic [23:0] rgb, input logic hit);
        px = x;
        py = y;
        @(negedge clk);
        chk({tag, "_rgb"}, {red_b, green_b, blue_b}, rgb);
        chk({tag, "_hit"}, hit_b, hit);
    endtask

    initial begin
        // Asynchronous reset, checked before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pos_x_a", pos_x_a, 500);
        chk("rst_pos_y_a", pos_y_a, 150);
        chk("rst_pos_x_b", pos_x_b, 307);
        chk("rst_rgb_a", {red_a, green_a, blue_a}, 24'h000000);
        chk("rst_hit_a", hit_a, 1'b0);

        // Release with vsync held high: no tick, no motion over 10 cycles.
        @(negedge clk);
        en_a = 1'b1;
        en_b = 1'b1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("hold_pos_x_a", pos_x_a, 500);
        chk("hold_pos_y_a", pos_y_a, 150);
        chk("hold_pos_x_b", pos_x_b, 307);
        chk("hold_rgb_a", {red_a, green_a, blue_a}, 24'h000000);
        chk("hold_hit_a", hit_a, 1'b0);
        en_a = 1'b0;
        en_b = 1'b0;
        v_sync = 1'b0;
        @(negedge clk);

        // Lookup at reset position.
        pix_a("opaque", 16'd548, 16'd166, 24'h05C5FF, 1'b1);
        pix_a("corner", 16'd500, 16'd150, 24'h000000, 1'b0);
        pix_a("right_out", 16'd628, 16'd166, 24'h000000, 1'b0);
        pix_a("above_out", 16'd548, 16'd149, 24'h000000, 1'b0);

        // Disabled ticks leave both instances in place.
        repeat (5) tick();
        chk("dis_pos_x_a", pos_x_a, 500);
        chk("dis_pos_x_b", pos_x_b, 307);
        chk("dis_pos_y_b", pos_y_b, 150);

        // Tick sharing an edge with a lookup: pixel uses the old position.
        en_a = 1'b1;
        px = 16'd548;
        py = 16'd166;
        v_sync = 1'b1;
        @(negedge clk);
        chk("coin_hit_old", hit_a, 1'b1);
        chk("coin_rgb_old", {red_a, green_a, blue_a}, 24'h05C5FF);
        chk("coin_pos_new", pos_x_a, 505);
        v_sync = 1'b0;
        @(negedge clk);
        chk("coin_hit_new", hit_a, 1'b0);

        // Walk A to the right bound.
        repeat (98) tick();
        chk("walk_995", pos_x_a, 995);
        chk("walk_y", pos_y_a, 150);
        tick();
        chk("clamp_max", pos_x_a, 1000);
        // Mirrored column: screen column 9 maps to grid column 6.
        pix_a("flip_hit", 16'd1072, 16'd166, 24'h05C5FF, 1'b1);
        pix_a("flip_miss", 16'd1048, 16'd166, 24'h000000, 1'b0);
        tick();
        chk("back_995", pos_x_a, 995);
        en_a = 1'b0;

        // Instance B: both axes bouncing.
        en_b = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("b_x_t%0d", i + 1), pos_x_b, exp_xb[i]);
            chk($sformatf("b_y_t%0d", i + 1), pos_y_b, exp_yb[i]);
            if (i == 3) begin
                pix_b("b_min_hit", 16'd348, 16'd566, 24'h05C5FF, 1'b1);
            end
            if (i == 4) begin
                pix_b("b_flipy_hit", 16'd353, 16'd704, 24'h05C5FF, 1'b1);
                pix_b("b_flipy_miss", 16'd353, 16'd616, 24'h000000, 1'b0);
            end
        end

        // Reset in the middle of a tick abandons it; motion restarts from START.
        en_a = 1'b1;
        v_sync = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_x_a", pos_x_a, 500);
        chk("mid_rst_x_b", pos_x_b, 307);
        chk("mid_rst_y_b", pos_y_b, 150);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_hold", pos_x_a, 500);
        v_sync = 1'b0;
        @(negedge clk);
        tick();
        chk("post_rst_x_a", pos_x_a, 505);
        chk("post_rst_x_b", pos_x_b, 312);
        chk("post_rst_y_b", pos_y_b, 250);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sprite_mover_compositor.md
SPRITE_MOVER_COMPOSITOR -- requirements
Module: sprite_mover_compositor

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  SCALE_SHIFT  3  log2 pixel magnification; sprite extent = 16<<SCALE_SHIFT screen pixels
  START_X  500  reset X position; START_Y  150  reset Y position
  MIN_X  300  left bound; MAX_X  1000  right bound
  MIN_Y  0  top bound; MAX_Y  600  bottom bound
  STEP_X  5  X pixels per frame; STEP_Y  0  Y pixels per frame (0 = no vertical motion)
  SPRITE_DATA  all-zero  16x16 grid of 2-bit palette indices, row 0 first, column 0 first
  PALETTE  {000000,05C5FF,8ED8ED,FFFFFF}  4 x 24-bit RGB; index 0 is transparent
REQ-002 Ports SHALL be, one per line (name direction width meaning):
  i_clk  in  1  pixel clock
  i_rst_n  in  1  reset, asynchronous, active-low
  i_x  in  16  current scan X
  i_y  in  16  current scan Y
  i_v_sync  in  1  vertical sync, synchronous to i_clk; rising edge = frame tick
  i_enable  in  1  motion enable, sampled on frame tick
  o_red, o_green, o_blue  out  8 each  pixel colour
  o_sprite_hit  out  1  opaque sprite pixel present
  o_pos_x, o_pos_y  out  16 each  current sprite top-left position
REQ-003 One clock and an asynchronous, active-low reset SHALL be used; all state SHALL be clocked by i_clk, and i_v_sync SHALL NOT be used as a clock.

Function
REQ-004 Frame tick SHALL be a one-cycle pulse when i_v_sync=1 and its registered copy is 0.
REQ-005 On a tick with i_enable=1, each axis SHALL update once; with i_enable=0, position and direction SHALL hold.
REQ-006 X moving right: next = x+STEP_X; if next >= MAX_X, x<=MAX_X, dir_x<=left, flip_x<=1; else x<=next.
REQ-007 X moving left: if x < MIN_X+STEP_X, x<=MIN_X, dir_x<=right, flip_x<=0; else x<=x-STEP_X. No unsigned underflow is permitted.
REQ-008 Y axis SHALL follow REQ-006/007 with MIN_Y, MAX_Y, STEP_Y, dir_y (down=+), flip_y.
REQ-009 Bound arithmetic SHALL use 17-bit intermediates; position SHALL never leave [MIN, MAX].
REQ-010 Hit window: i_x in [pos_x, pos_x+(16<<SCALE_SHIFT)), likewise Y; compare in 17 bits, no wrap.
REQ-011 Grid column = (i_x-pos_x)>>SCALE_SHIFT, mirrored to 15-col when flip_x=1; row likewise with flip_y.
REQ-012 Pixel path SHALL be registered, latency exactly 1 cycle: inputs at edge N -> outputs valid after edge N+1.
REQ-013 Inside window, colour outputs SHALL equal PALETTE[index]; outside, 0x00 on all three; never X.
REQ-014 o_sprite_hit SHALL be 1 only inside window and index != 0.
REQ-015 If a tick and pixel lookup share an edge, lookup SHALL use the pre-update position and flips.
REQ-016 o_pos_x/o_pos_y SHALL reflect the position registers directly (no extra latency).
REQ-017 Parameters SHALL satisfy MIN < MAX and STEP <= MAX-MIN; out-of-spec values are unsupported.

Reset
REQ-018 On i_rst_n=0, immediately: pos=(START_X,START_Y), dir_x=right, dir_y=down, flips 0, colour outputs 0, o_sprite_hit 0, vsync copy register 1 (a level-high i_v_sync at release SHALL NOT tick).
REQ-019 Reset mid-frame or mid-move SHALL abandon the update; the first tick after release moves from START.

Verification
REQ-020 Reset with i_v_sync held 1, release, clock 10 cycles -> o_pos=(500,150), no movement, all outputs 0.
REQ-021 Force pos_x 995 via ticks (STEP_X 5), tick -> 1000, dir left, flip_x 1; next tick -> 995.
REQ-022 MIN_X 300, pos_x 302 moving left, tick -> 300 (clamped), dir right, flip_x 0; next tick -> 305.
REQ-023 SPRITE_DATA row 2 col 6 = 1, others 0, pos (500,150), i=(548,166) -> next cycle RGB 05C5FF, hit 1; i=(500,150) -> RGB 000000, hit 0.
REQ-024 Same data with flip_x=1, i=(572,166) (col 9 mirrored to 6) -> RGB 05C5FF, hit 1; i=(548,166) -> hit 0.
REQ-025 i_enable=0 over 5 ticks -> position unchanged; tick coinciding with i_x at window edge -> pixel uses old position.
